// File: rtl/npu_pkg.sv
// -----------------------------------------------------------------------------
// npu_pkg
// Shared types and constants for the tinyNPU job sequencer slice.
//   seq_state_t     : sequencer FSM states
//   LD_SEL_W/LD_SEL_A : ld_sel encodings (weights / activations)
//   DEF_TILE_BYTES  : default address stride between consecutive tiles
// -----------------------------------------------------------------------------
package npu_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LD_W   = 3'd1,
        S_LD_GAP = 3'd2,   // one idle cycle between weight and activation loads
        S_LD_A   = 3'd3,
        S_MAC    = 3'd4,
        S_ST     = 3'd5,
        S_DONE   = 3'd6
    } seq_state_t;

    localparam logic LD_SEL_W = 1'b0;
    localparam logic LD_SEL_A = 1'b1;

    localparam int unsigned DEF_TILE_BYTES = 32;

endpackage

// File: rtl/npu_addr_gen.sv
// -----------------------------------------------------------------------------
// npu_addr_gen
// Per-tile address generator for the weight, activation and output streams.
// Each address is base + tile_index * TILE_BYTES, kept incrementally: bases
// are loaded when a job is accepted and every stream steps by TILE_BYTES when
// the sequencer moves to the next tile. Arithmetic wraps modulo 2^ADDR_W.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   load                  load the three bases (job accepted)
//   advance               step all streams to the next tile
//   w_base/a_base/o_base  base addresses sampled on load
//   w_addr/a_addr/o_addr  current tile addresses
// -----------------------------------------------------------------------------
module npu_addr_gen
    import npu_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int TILE_BYTES = DEF_TILE_BYTES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
    input  logic [ADDR_W-1:0] w_base,
    input  logic [ADDR_W-1:0] a_base,
    input  logic [ADDR_W-1:0] o_base,
    output logic [ADDR_W-1:0] w_addr,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] o_addr
);

    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(TILE_BYTES);

    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [ADDR_W-1:0] a_addr_q, a_addr_d;
    logic [ADDR_W-1:0] o_addr_q, o_addr_d;

    always_comb begin
        w_addr_d = w_addr_q;
        a_addr_d = a_addr_q;
        o_addr_d = o_addr_q;
        if (load) begin
            w_addr_d = w_base;
            a_addr_d = a_base;
            o_addr_d = o_base;
        end else if (advance) begin
            w_addr_d = w_addr_q + STRIDE;
            a_addr_d = a_addr_q + STRIDE;
            o_addr_d = o_addr_q + STRIDE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_addr_q <= '0;
            a_addr_q <= '0;
            o_addr_q <= '0;
        end else begin
            w_addr_q <= w_addr_d;
            a_addr_q <= a_addr_d;
            o_addr_q <= o_addr_d;
        end
    end

    assign w_addr = w_addr_q;
    assign a_addr = a_addr_q;
    assign o_addr = o_addr_q;

endmodule

// File: rtl/npu_job_sequencer.sv
// -----------------------------------------------------------------------------
// npu_job_sequencer
// Sequences one tinyNPU job tile by tile: load weights, load activations,
// run the MAC array for K_DIM cycles, store results, then the next tile.
// Optional feature macro: NPU_IRQ_EN adds a level irq output.
// Ports:
//   ACLK, ARESET                  clock, asynchronous active-high reset
//   cfg_start                     start pulse (accepted only when idle)
//   cfg_num_tiles, cfg_*_base     job config, latched on accepted start
//   sts_clr                       clears sts_done (and irq)
//   ld_req/ld_sel/ld_addr/ld_ack  load handshake (req held until ack)
//   mac_clr/mac_en                accumulator clear / MAC enable
//   st_req/st_addr/st_ack         store handshake (req held until ack)
//   sts_busy/sts_done/sts_tile    status to the register file
//   irq                           level interrupt (NPU_IRQ_EN only)
// -----------------------------------------------------------------------------
module npu_job_sequencer
    import npu_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int TILE_CNT_W = 8,
    parameter int K_DIM      = 8,
    parameter int TILE_BYTES = DEF_TILE_BYTES
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  cfg_start,
    input  logic [TILE_CNT_W-1:0] cfg_num_tiles,
    input  logic [ADDR_W-1:0]     cfg_w_base,
    input  logic [ADDR_W-1:0]     cfg_a_base,
    input  logic [ADDR_W-1:0]     cfg_o_base,
    input  logic                  sts_clr,
    output logic                  ld_req,
    output logic                  ld_sel,
    output logic [ADDR_W-1:0]     ld_addr,
    input  logic                  ld_ack,
    output logic                  mac_clr,
    output logic                  mac_en,
    output logic                  st_req,
    output logic [ADDR_W-1:0]     st_addr,
    input  logic                  st_ack,
    output logic                  sts_busy,
    output logic                  sts_done,
    output logic [TILE_CNT_W-1:0] sts_tile
`ifdef NPU_IRQ_EN
    ,
    output logic                  irq
`endif
);

    localparam int MAC_CNT_W = $clog2(K_DIM + 1);
    localparam logic [MAC_CNT_W-1:0] MAC_LAST = MAC_CNT_W'(K_DIM - 1);

    seq_state_t              state_q, state_d;
    logic [TILE_CNT_W-1:0]   tile_q, tile_d;
    logic [TILE_CNT_W-1:0]   num_tiles_q, num_tiles_d;
    logic [MAC_CNT_W-1:0]    mac_cnt_q, mac_cnt_d;
    logic                    done_q, done_d;

    logic                    start_ok;
    logic                    start_job;
    logic                    done_set;
    logic                    last_tile;
    logic                    addr_adv;
    logic [ADDR_W-1:0]       w_addr, a_addr, o_addr;

    // Starts are only honoured from IDLE; anything else is silently dropped.
    assign start_ok  = cfg_start && (state_q == S_IDLE);
    assign start_job = start_ok && (cfg_num_tiles != '0);
    assign last_tile = (tile_q == num_tiles_q - TILE_CNT_W'(1));
    assign addr_adv  = (state_q == S_ST) && st_ack && !last_tile;

    npu_addr_gen #(
        .ADDR_W     (ADDR_W),
        .TILE_BYTES (TILE_BYTES)
    ) u_addr_gen (
        .clk     (ACLK),
        .rst     (ARESET),
        .load    (start_job),
        .advance (addr_adv),
        .w_base  (cfg_w_base),
        .a_base  (cfg_a_base),
        .o_base  (cfg_o_base),
        .w_addr  (w_addr),
        .a_addr  (a_addr),
        .o_addr  (o_addr)
    );

    always_comb begin
        state_d     = state_q;
        tile_d      = tile_q;
        num_tiles_d = num_tiles_q;
        mac_cnt_d   = mac_cnt_q;
        done_set    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_job) begin
                    state_d     = S_LD_W;
                    tile_d      = '0;
                    num_tiles_d = cfg_num_tiles;
                end else if (start_ok) begin
                    // Empty job completes immediately without leaving IDLE.
                    done_set = 1'b1;
                end
            end
            S_LD_W:   if (ld_ack) state_d = S_LD_GAP;
            S_LD_GAP: state_d = S_LD_A;
            S_LD_A:   if (ld_ack) state_d = S_MAC;
            S_MAC: begin
                if (mac_cnt_q == MAC_LAST) begin
                    state_d   = S_ST;
                    mac_cnt_d = '0;
                end else begin
                    mac_cnt_d = mac_cnt_q + MAC_CNT_W'(1);
                end
            end
            S_ST: begin
                if (st_ack) begin
                    if (last_tile) begin
                        // Tile index is left on the last tile for software.
                        state_d  = S_DONE;
                        done_set = 1'b1;
                    end else begin
                        state_d = S_LD_W;
                        tile_d  = tile_q + TILE_CNT_W'(1);
                    end
                end
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        // Clear first so a coincident completion (set) takes priority.
        done_d = done_q;
        if (sts_clr || start_ok) done_d = 1'b0;
        if (done_set)            done_d = 1'b1;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q     <= S_IDLE;
            tile_q      <= '0;
            num_tiles_q <= '0;
            mac_cnt_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tile_q      <= tile_d;
            num_tiles_q <= num_tiles_d;
            mac_cnt_q   <= mac_cnt_d;
            done_q      <= done_d;
        end
    end

    // All outputs decode directly from reset flops, so ARESET zeroes them
    // in the same cycle it is asserted.
    assign ld_req   = (state_q == S_LD_W) || (state_q == S_LD_A);
    assign ld_sel   = (state_q == S_LD_A) ? LD_SEL_A : LD_SEL_W;
    assign ld_addr  = (state_q == S_LD_A) ? a_addr : w_addr;
    assign mac_en   = (state_q == S_MAC);
    assign mac_clr  = mac_en && (mac_cnt_q == '0);
    assign st_req   = (state_q == S_ST);
    assign st_addr  = o_addr;
    assign sts_busy = (state_q != S_IDLE) && (state_q != S_DONE);
    assign sts_done = done_q;
    assign sts_tile = tile_q;

`ifdef NPU_IRQ_EN
    // irq has exactly the set/clear rules of the sticky done flag.
    assign irq = done_q;
`endif

endmodule
